// File: rtl/ldpc_stream_encode.sv
// Systematic LDPC encoder with a runtime-loadable parity generator.
// Info words in on valid/ready, parity folded LANES bits per cycle.
module ldpc_stream_encode #(
  parameter int N     = 6,
  parameter int K     = 3,
  parameter int LANES = 1,
  parameter int ROW_W = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_g_we,
  input  logic [ROW_W-1:0] i_g_row,
  input  logic [N-K-1:0]   i_g_data,
  output logic             o_g_ack,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [K-1:0]     i_info,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_codeword,
  output logic             o_busy
);

  localparam int PW    = N - K;
  localparam int BEATS = K / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ROW_W:0] K_LIM = (ROW_W + 1)'(K);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if ((K % LANES) != 0 || K <= 0 || K >= N) begin : g_bad_cfg
    $error("ldpc_stream_encode: need 0 < K < N and K %% LANES == 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [PW-1:0]    p_q [K];
  logic [K-1:0]     info_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_n;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             row_ok;
  logic             last_beat;

  assign row_ok    = {1'b0, i_g_row} < K_LIM;
  assign last_beat = cnt_q == LAST;

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n = state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    o_g_ack = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_g_ack = i_g_we & row_ok;
        accept  = i_valid;
        if (i_valid) state_n = ACC;
      end
      ACC: begin
        o_busy = 1'b1;
        if (last_beat) state_n = OUT;
      end
      OUT: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Fold the info bits belonging to this beat into the parity
  always_comb begin
    acc_n = acc_q;
    for (int i = 0; i < K; i++) begin
      if (cnt_q == CNT_W'(i / LANES) && info_q[i])
        acc_n = acc_n ^ p_q[i];
    end
  end

  // Generator rows; writable only while idle
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < K; i++) p_q[i] <= '0;
    end else if (o_g_ack) begin
      for (int i = 0; i < K; i++) begin
        if (i_g_row == ROW_W'(i)) p_q[i] <= i_g_data;
      end
    end
  end

  // Info latch, accumulator, beat counter and output word
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      info_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      o_codeword <= '0;
    end else if (accept) begin
      info_q <= i_info;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (state == ACC) begin
      acc_q <= acc_n;
      cnt_q <= cnt_q + 1'b1;
      if (last_beat) o_codeword <= {acc_n, info_q};
    end
  end

endmodule

// File: tb/tb_ldpc_stream_encode.sv
// Scoreboard bench for ldpc_stream_encode.
// Runs a LANES=1 and a LANES=3 instance side by side.
module tb_ldpc_stream_encode;

  localparam int N  = 6;
  localparam int K  = 3;
  localparam int PW = N - K;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          g_we;
  logic [1:0]    g_row;
  logic [PW-1:0] g_data;
  logic          i_valid;
  logic [K-1:0]  i_info;
  logic          i_ready;
  logic          ack  [2];
  logic          rdy  [2];
  logic          ov   [2];
  logic          busy [2];
  logic [N-1:0]  cw   [2];

  logic [PW-1:0] pm [K];
  logic [N-1:0]  expq [2][$];
  int            lat_exp [2] = '{3, 1};
  int            total = 0;
  int            passed = 0;
  bit            rand_rdy = 1'b0;

  always #5 clk = ~clk;

  ldpc_stream_encode #(.N(N), .K(K), .LANES(1)) u_l1 (
    .clk(clk), .i_rst_n(rst_n),
    .i_g_we(g_we), .i_g_row(g_row), .i_g_data(g_data),
    .o_g_ack(ack[0]), .i_valid(i_valid), .o_ready(rdy[0]),
    .i_info(i_info), .o_valid(ov[0]), .i_ready(i_ready),
    .o_codeword(cw[0]), .o_busy(busy[0])
  );

  ldpc_stream_encode #(.N(N), .K(K), .LANES(3)) u_l3 (
    .clk(clk), .i_rst_n(rst_n),
    .i_g_we(g_we), .i_g_row(g_row), .i_g_data(g_data),
    .o_g_ack(ack[1]), .i_valid(i_valid), .o_ready(rdy[1]),
    .i_info(i_info), .o_valid(ov[1]), .i_ready(i_ready),
    .o_codeword(cw[1]), .o_busy(busy[1])
  );

  // GF(2) product info * P, one parity column at a time
  function automatic logic [PW-1:0] parity(input logic [K-1:0] info);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < PW; c++)
      for (int i = 0; i < K; i++)
        r[c] = r[c] ^ (info[i] & pm[i][c]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] row, input logic [PW-1:0] data);
    bit ok;
    ok     = row < K;
    g_we   = 1'b1;
    g_row  = row;
    g_data = data;
    #1;
    check("load_ack_l1", ack[0], ok);
    check("load_ack_l3", ack[1], ok);
    if (ok) pm[row] = data;
    tick();
    g_we = 1'b0;
  endtask

  // wmode: 0 none, 1 write with accept, 2 write during ACC
  task automatic send(input logic [K-1:0] info, input int wmode,
                      input logic [1:0] wrow, input logic [PW-1:0] wdata);
    int      w;
    int      lat [2];
    bit      ok;
    logic [PW-1:0] par;
    w = 0;
    while (!(rdy[0] && rdy[1]) && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      total++;
      $display("FAIL ready_timeout: got busy required idle");
      return;
    end
    i_valid = 1'b1;
    i_info  = info;
    if (wmode == 1) begin
      ok     = wrow < K;
      g_we   = 1'b1;
      g_row  = wrow;
      g_data = wdata;
      #1;
      check("idle_wr_ack_l1", ack[0], ok);
      check("idle_wr_ack_l3", ack[1], ok);
      if (ok) pm[wrow] = wdata;
    end
    par = parity(info);
    expq[0].push_back({par, info});
    expq[1].push_back({par, info});
    tick();
    i_valid = 1'b0;
    i_info  = K'($urandom);
    g_we    = 1'b0;
    if (wmode == 2) begin
      g_we   = 1'b1;
      g_row  = wrow;
      g_data = wdata;
      #1;
      check("acc_wr_ack_l1", ack[0], 0);
      check("acc_wr_ack_l3", ack[1], 0);
    end
    lat = '{-1, -1};
    for (int c = 0; c < 8 && (lat[0] < 0 || lat[1] < 0); c++) begin
      @(negedge clk);
      if (ov[0] && lat[0] < 0) lat[0] = c;
      if (ov[1] && lat[1] < 0) lat[1] = c;
      if (c == 1) g_we = 1'b0;
    end
    g_we = 1'b0;
    check("latency_l1", lat[0], lat_exp[0]);
    check("latency_l3", lat[1], lat_exp[1]);
    tick();
  endtask

  // Monitor: every presented word must match the head of its queue
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          if (expq[d].size() == 0) begin
            total++;
            $display("FAIL unexpected_word_d%0d: got %0h required none",
                     d, cw[d]);
          end else begin
            check($sformatf("codeword_d%0d", d), cw[d], expq[d][0]);
            if (i_ready) void'(expq[d].pop_front());
          end
        end
      end
    end
  end

  // Random downstream backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int w;
    for (int i = 0; i < K; i++) pm[i] = '0;
    rst_n   = 1'b0;
    g_we    = 1'b0;
    g_row   = '0;
    g_data  = '0;
    i_valid = 1'b0;
    i_info  = '0;
    i_ready = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", ov[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_cw", cw[d], 0);
    end
    rst_n = 1'b1;
    tick();

    send(3'b010, 0, 0, 0);

    load(2'd0, 3'b011);
    load(2'd1, 3'b101);
    load(2'd2, 3'b110);
    send(3'b010, 0, 0, 0);
    send(3'b111, 0, 0, 0);

    i_ready = 1'b0;
    send(3'b001, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      check("stall_ready_l1", rdy[0], 0);
      check("stall_ready_l3", rdy[1], 0);
      check("stall_valid_l1", ov[0], 1);
      check("stall_valid_l3", ov[1], 1);
      i_valid = (c == 2);
      i_info  = 3'b110;
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("post_hs_valid", ov[d], 0);
      check("post_hs_ready", rdy[d], 1);
    end

    send(3'b010, 2, 2'd1, 3'b111);
    load(2'd3, 3'b111);
    send(3'b111, 0, 0, 0);

    i_valid = 1'b1;
    i_info  = 3'b111;
    tick();
    i_valid = 1'b0;
    check("acc_busy_l1", busy[0], 1);
    check("acc_busy_l3", busy[1], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("midrst_valid", ov[d], 0);
      check("midrst_busy", busy[d], 0);
      check("midrst_cw", cw[d], 0);
    end
    for (int i = 0; i < K; i++) pm[i] = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(3'b111, 0, 0, 0);

    for (int i = 0; i < K; i++) load(2'(i), PW'($urandom));
    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++)
      send(K'($urandom), $urandom_range(0, 2),
           2'($urandom_range(0, 3)), PW'($urandom));
    rand_rdy = 1'b0;
    tick();
    i_ready = 1'b1;
    w = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && w < 20) begin
      tick();
      w++;
    end
    check("drain_l1", expq[0].size(), 0);
    check("drain_l3", expq[1].size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
